// File: rtl/me_best_mv_collector_if.sv
// SAD sample stream (in) and best-MV result stream (out) for me_best_mv_collector.
// master = SAD producer / result consumer side, slave = collector side.
interface me_best_mv_collector_if #(
  parameter int SAD_W = 16,
  parameter int COL_W = 5,
  parameter int ROW_W = 7
);
  logic             sad_valid;
  logic [1:0]       sad_cb;
  logic [SAD_W-1:0] sad_value;
  logic [COL_W-1:0] sad_col;
  logic [ROW_W-1:0] sad_row;

  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_cb;
  logic             res_hit;
  logic [SAD_W-1:0] res_sad;
  logic [COL_W:0]   res_mv_x;
  logic [ROW_W:0]   res_mv_y;

  modport master (
    output sad_valid, sad_cb, sad_value, sad_col, sad_row, res_ready,
    input  res_valid, res_cb, res_hit, res_sad, res_mv_x, res_mv_y
  );

  modport slave (
    input  sad_valid, sad_cb, sad_value, sad_col, sad_row, res_ready,
    output res_valid, res_cb, res_hit, res_sad, res_mv_x, res_mv_y
  );
endinterface

// File: rtl/me_best_mv_collector.sv
// Tracks the minimum-SAD sample and its MV per sub-block, then drains 4 winners in CB order.
// Optional macro ME_MV_COST_EN: adds lambda port and MV-cost-weighted compare metric.
module me_best_mv_collector #(
  parameter int SAD_W      = 16,
  parameter int COL_W      = 5,
  parameter int ROW_W      = 7,
  parameter int COL_CENTER = 16,
  parameter int ROW_CENTER = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic search_done,
`ifdef ME_MV_COST_EN
  input  logic [3:0] lambda,
`endif
  me_best_mv_collector_if.slave bus,
  output logic busy,
  output logic done
);

`ifdef ME_MV_COST_EN
  localparam int MET_W = SAD_W + 9;
`else
  localparam int MET_W = SAD_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic                    done_q, done_d;
  logic [3:0]              hit_q, hit_d;
  logic [3:0][SAD_W-1:0]   sad_q, sad_d;
  logic [3:0][COL_W:0]     mvx_q, mvx_d;
  logic [3:0][ROW_W:0]     mvy_q, mvy_d;
`ifdef ME_MV_COST_EN
  logic [3:0][MET_W-1:0]   met_q, met_d;
  logic [COL_W:0]          abs_x;
  logic [ROW_W:0]          abs_y;
`endif

  logic [COL_W:0]   samp_mvx;
  logic [ROW_W:0]   samp_mvy;
  logic [MET_W-1:0] cur_met, best_met;
  logic             drain_vld;

  // Zero-extend the unsigned indices, then subtract in two's complement.
  assign samp_mvx = {1'b0, bus.sad_col} - (COL_W+1)'(COL_CENTER);
  assign samp_mvy = {1'b0, bus.sad_row} - (ROW_W+1)'(ROW_CENTER);

`ifdef ME_MV_COST_EN
  assign abs_x    = samp_mvx[COL_W] ? -samp_mvx : samp_mvx;
  assign abs_y    = samp_mvy[ROW_W] ? -samp_mvy : samp_mvy;
  assign cur_met  = MET_W'(bus.sad_value)
                  + MET_W'(lambda) * (MET_W'(abs_x) + MET_W'(abs_y));
  assign best_met = met_q[bus.sad_cb];
`else
  assign cur_met  = bus.sad_value;
  assign best_met = sad_q[bus.sad_cb];
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    hit_d   = hit_q;
    sad_d   = sad_q;
    mvx_d   = mvx_q;
    mvy_d   = mvy_q;
`ifdef ME_MV_COST_EN
    met_d   = met_q;
`endif
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (start) begin
          state_d = S_COLLECT;
          for (int unsigned i = 0; i < 4; i++) begin
            hit_d[i] = 1'b0;
            sad_d[i] = '1;
            mvx_d[i] = '0;
            mvy_d[i] = '0;
`ifdef ME_MV_COST_EN
            met_d[i] = '1;
`endif
          end
        end else if (state_q == S_COLLECT) begin
          // Strict less-than: on a tie the earlier sample stays.
          if (bus.sad_valid && (!hit_q[bus.sad_cb] || cur_met < best_met)) begin
            hit_d[bus.sad_cb] = 1'b1;
            sad_d[bus.sad_cb] = bus.sad_value;
            mvx_d[bus.sad_cb] = samp_mvx;
            mvy_d[bus.sad_cb] = samp_mvy;
`ifdef ME_MV_COST_EN
            met_d[bus.sad_cb] = cur_met;
`endif
          end
          if (search_done) begin
            state_d = S_DRAIN;
            idx_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (bus.res_ready) begin
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      hit_q   <= '0;
      sad_q   <= '1;
      mvx_q   <= '0;
      mvy_q   <= '0;
`ifdef ME_MV_COST_EN
      met_q   <= '1;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      sad_q   <= sad_d;
      mvx_q   <= mvx_d;
      mvy_q   <= mvy_d;
`ifdef ME_MV_COST_EN
      met_q   <= met_d;
`endif
    end
  end

  // Result word is decoded from registered state so reset clears it immediately.
  assign drain_vld     = (state_q == S_DRAIN);
  assign bus.res_valid = drain_vld;
  assign bus.res_cb    = drain_vld ? idx_q        : '0;
  assign bus.res_hit   = drain_vld ? hit_q[idx_q] : 1'b0;
  assign bus.res_sad   = drain_vld ? sad_q[idx_q] : '0;
  assign bus.res_mv_x  = drain_vld ? mvx_q[idx_q] : '0;
  assign bus.res_mv_y  = drain_vld ? mvy_q[idx_q] : '0;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_me_best_mv_collector.sv
// Self-checking bench for me_best_mv_collector: directed table, corner sequences and
// randomized searches compared against a queue-based reference model.
module tb_me_best_mv_collector;
  logic clk = 1'b0;
  logic rst_n, start, search_done, busy, done;
  logic [3:0] lambda;
  int checks = 0;
  int errors = 0;

  me_best_mv_collector_if #(.SAD_W(16), .COL_W(5), .ROW_W(7)) bus ();

  me_best_mv_collector #(
    .SAD_W(16), .COL_W(5), .ROW_W(7), .COL_CENTER(16), .ROW_CENTER(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .search_done (search_done),
`ifdef ME_MV_COST_EN
    .lambda      (lambda),
`endif
    .bus         (bus),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {int cb; int sad; int col; int row; int lam;} samp_t;
  samp_t samples[$];
  int exp_hit[4], exp_sad[4], exp_mvx[4], exp_mvy[4];

  typedef struct {
    int n; int cb;
    int s0; int c0; int r0;
    int s1; int c1; int r1;
    int e_sad; int e_mvx; int e_mvy;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void set_empty();
    for (int i = 0; i < 4; i++) begin
      exp_hit[i] = 0; exp_sad[i] = 65535; exp_mvx[i] = 0; exp_mvy[i] = 0;
    end
  endfunction

  // Reference: scan the collected samples in arrival order, strict improvement wins.
  function automatic void model_eval();
    int best[4];
    set_empty();
    foreach (samples[j]) begin
      int mx, my, met;
      mx  = samples[j].col - 16;
      my  = samples[j].row - 32;
`ifdef ME_MV_COST_EN
      met = samples[j].sad + samples[j].lam * (iabs(mx) + iabs(my));
`else
      met = samples[j].sad;
`endif
      if (exp_hit[samples[j].cb] == 0 || met < best[samples[j].cb]) begin
        exp_hit[samples[j].cb] = 1;
        exp_sad[samples[j].cb] = samples[j].sad;
        exp_mvx[samples[j].cb] = mx;
        exp_mvy[samples[j].cb] = my;
        best[samples[j].cb]    = met;
      end
    end
  endfunction

  task automatic begin_search();
    samples.delete();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send(input int cb, input int sad, input int col, input int row,
                      input int lam, input bit with_done);
    bus.sad_valid = 1'b1;
    bus.sad_cb    = 2'(cb);
    bus.sad_value = 16'(sad);
    bus.sad_col   = 5'(col);
    bus.sad_row   = 7'(row);
    lambda        = 4'(lam);
    search_done   = with_done;
    samples.push_back('{cb, sad, col, row, lam});
    step();
    bus.sad_valid = 1'b0;
    search_done   = 1'b0;
  endtask

  task automatic end_search();
    search_done = 1'b1; step(); search_done = 1'b0;
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low 5 cycles while cb1 is presented.
  task automatic drain(input int mode);
    int k = 0;
    int cyc = 0;
    int stall = 0;
    bit rdy, hs;
    while (k < 4 && cyc < 200) begin
      chk("res_valid", int'(bus.res_valid), 1);
      if (!bus.res_valid) break;
      chk("done_during_drain", int'(done), 0);
      chk("busy_during_drain", int'(busy), 1);
      chk("res_cb", int'(bus.res_cb), k);
      chk("res_hit", int'(bus.res_hit), exp_hit[k]);
      chk("res_sad", int'(bus.res_sad), exp_sad[k]);
      chk("res_mv_x", int'($signed(bus.res_mv_x)), exp_mvx[k]);
      chk("res_mv_y", int'($signed(bus.res_mv_y)), exp_mvy[k]);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(k == 1 && stall < 5);
          if (!rdy) stall++;
        end
      endcase
      bus.res_ready = rdy;
      hs = rdy && bus.res_valid;
      step();
      cyc++;
      if (hs) k++;
    end
    bus.res_ready = 1'b0;
    if (k < 4) chk("drain_words", k, 4);
    chk("res_valid_after_cb3", int'(bus.res_valid), 0);
    chk("done_pulse", int'(done), 1);
    chk("busy_after_cb3", int'(busy), 0);
    step();
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; search_done = 1'b0; lambda = '0;
    bus.sad_valid = 1'b0; bus.sad_cb = '0; bus.sad_value = '0;
    bus.sad_col = '0; bus.sad_row = '0; bus.res_ready = 1'b0;

    vecs[0] = '{2, 0, 100, 16, 32,   80, 18, 30,   80,   2,  -2};
    vecs[1] = '{2, 1,  50,  0,  0,   50, 31, 63,   50, -16, -32};
    vecs[2] = '{1, 2, 1234, 5, 100,   0,  0,  0, 1234, -11,  68};
    vecs[3] = '{1, 3, 65535, 31, 127, 0,  0,  0, 65535, 15,  95};
    vecs[4] = '{2, 1,   7, 10, 10,    8,  0,  0,    7,  -6, -22};

    step(); step();
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_res_cb", int'(bus.res_cb), 0);
    chk("rst_res_hit", int'(bus.res_hit), 0);
    chk("rst_res_sad", int'(bus.res_sad), 0);
    chk("rst_res_mv_x", int'(bus.res_mv_x), 0);
    chk("rst_res_mv_y", int'(bus.res_mv_y), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    step();

    // Directed table: one CB fed per search, all others must drain empty.
    for (int v = 0; v < 5; v++) begin
      begin_search();
      chk("busy_collect", int'(busy), 1);
      send(vecs[v].cb, vecs[v].s0, vecs[v].c0, vecs[v].r0, 0, 1'b0);
      if (vecs[v].n > 1) send(vecs[v].cb, vecs[v].s1, vecs[v].c1, vecs[v].r1, 0, 1'b0);
      end_search();
      set_empty();
      exp_hit[vecs[v].cb] = 1;
      exp_sad[vecs[v].cb] = vecs[v].e_sad;
      exp_mvx[vecs[v].cb] = vecs[v].e_mvx;
      exp_mvy[vecs[v].cb] = vecs[v].e_mvy;
      drain(0);
    end

    // search_done while idle is ignored.
    end_search();
    chk("idle_done_ignored_valid", int'(bus.res_valid), 0);
    chk("idle_done_ignored_busy", int'(busy), 0);

    // Sample coinciding with search_done is included.
    begin_search();
    send(3, 5, 16, 32, 0, 1'b1);
    model_eval();
    drain(0);

    // Restart mid-collect drops earlier minima.
    begin_search();
    send(0, 10, 0, 0, 0, 1'b0);
    begin_search();
    send(0, 200, 20, 40, 0, 1'b0);
    end_search();
    model_eval();
    chk("restart_cb0_sad", exp_sad[0], 200);
    drain(0);

    // Backpressure on cb1; samples and start during drain must be ignored.
    begin_search();
    send(1, 300, 17, 33, 0, 1'b0);
    send(3, 400, 15, 31, 0, 1'b0);
    end_search();
    model_eval();
    bus.sad_valid = 1'b1; bus.sad_cb = 2'd3; bus.sad_value = '0;
    bus.sad_col = '0; bus.sad_row = '0;
    start = 1'b1;
    drain(2);
    bus.sad_valid = 1'b0; start = 1'b0;

`ifdef ME_MV_COST_EN
    begin_search();
    send(0, 100, 16, 32, 4, 1'b0);
    send(0, 90, 20, 32, 4, 1'b0);
    end_search();
    set_empty();
    exp_hit[0] = 1; exp_sad[0] = 100;
    drain(0);
`endif

    // Randomized searches against the reference model.
    for (int t = 0; t < 30; t++) begin
      int n;
      bit last_done;
      n = $urandom_range(0, 12);
      last_done = 1'($urandom_range(0, 1));
      begin_search();
      for (int s = 0; s < n; s++) begin
        int sad;
        if ($urandom_range(0, 3) == 0) sad = $urandom_range(0, 3);
        else sad = $urandom_range(0, 65535);
        if ($urandom_range(0, 3) == 0) step();
        send($urandom_range(0, 3), sad, $urandom_range(0, 31), $urandom_range(0, 127),
             $urandom_range(0, 15), (s == n - 1) && last_done);
      end
      if (n == 0 || !last_done) end_search();
      model_eval();
      drain(1);
    end

    // Reset during drain aborts immediately.
    begin_search();
    send(2, 42, 16, 32, 0, 1'b0);
    end_search();
    chk("pre_abort_valid", int'(bus.res_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_res_valid", int'(bus.res_valid), 0);
    chk("abort_busy", int'(busy), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_abort_valid", int'(bus.res_valid), 0);
    chk("post_abort_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
